// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW hazard stall, branch flush, data-memory wait.
// Optional macro FORWARDING_EN: restrict stalls to the EXE load-use case.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic             id_src1_en,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_ifid,
    output logic             bubble_idexe,
    output logic             flush,
    output logic             mem_freeze,
    output logic             hazard,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERR
    } state_e;

    state_e             state_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   stall_cnt_d;
    logic               hazard_raw;
    logic               mem_freeze_c;
    logic               stall_c;

`ifdef FORWARDING_EN
    logic unused_mem;
    assign unused_mem = ^{mem_dest, mem_wb_en};
    assign hazard_raw = exe_mem_r_en & exe_wb_en &
                        ((id_src1_en & (exe_dest == id_src1)) |
                         (id_two_src & (exe_dest == id_src2)));
`else
    logic unused_ld;
    assign unused_ld  = exe_mem_r_en;
    assign hazard_raw = (id_src1_en & exe_wb_en & (exe_dest == id_src1)) |
                        (id_src1_en & mem_wb_en & (mem_dest == id_src1)) |
                        (id_two_src & exe_wb_en & (exe_dest == id_src2)) |
                        (id_two_src & mem_wb_en & (mem_dest == id_src2));
`endif

    always_comb begin
        mem_freeze_c = ((state_q == RUN) & mem_req & ~mem_ready) |
                       ((state_q == MEM_WAIT) & ~mem_ready) |
                       (state_q == ERR);
        stall_c      = hazard_raw & ~mem_freeze_c & ~branch_taken;
        stall_cnt_d  = stall_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Outputs are forced low for the whole reset pulse, not just after the edge.
    always_comb begin
        freeze_pc    = 1'b0;
        freeze_ifid  = 1'b0;
        bubble_idexe = 1'b0;
        flush        = 1'b0;
        mem_freeze   = 1'b0;
        hazard       = 1'b0;
        mem_err      = 1'b0;
        stall_cnt    = stall_cnt_q;
        if (!rst) begin
            freeze_pc    = stall_c;
            freeze_ifid  = stall_c;
            bubble_idexe = stall_c;
            flush        = branch_taken & ~mem_freeze_c;
            mem_freeze   = mem_freeze_c;
            hazard       = hazard_raw;
            mem_err      = (state_q == ERR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_q <= RUN;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= ERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                ERR:     state_q <= ERR;
                default: state_q <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; a second instance uses a short timeout
// and a 2-bit stall counter to reach the error state and counter saturation quickly.
module tb_pipeline_hazard_ctrl;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        id_src1_en, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic        branch_taken, mem_req, mem_ready;

    logic        freeze_pc, freeze_ifid, bubble_idexe, flush, mem_freeze, hazard, mem_err;
    logic [15:0] stall_cnt;
    logic        t4_freeze_pc, t4_freeze_ifid, t4_bubble_idexe, t4_flush, t4_mem_freeze;
    logic        t4_hazard, t4_mem_err;
    logic [1:0]  t4_stall_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #50 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src1_en(id_src1_en), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc(freeze_pc), .freeze_ifid(freeze_ifid), .bubble_idexe(bubble_idexe),
        .flush(flush), .mem_freeze(mem_freeze), .hazard(hazard), .mem_err(mem_err),
        .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_t4 (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src1_en(id_src1_en), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc(t4_freeze_pc), .freeze_ifid(t4_freeze_ifid), .bubble_idexe(t4_bubble_idexe),
        .flush(t4_flush), .mem_freeze(t4_mem_freeze), .hazard(t4_hazard), .mem_err(t4_mem_err),
        .stall_cnt(t4_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic ctl(input string tag, input bit fp, input bit fi, input bit bb,
                       input bit fl, input bit mf);
        check({tag, ".freeze_pc"},    freeze_pc,    fp);
        check({tag, ".freeze_ifid"},  freeze_ifid,  fi);
        check({tag, ".bubble_idexe"}, bubble_idexe, bb);
        check({tag, ".flush"},        flush,        fl);
        check({tag, ".mem_freeze"},   mem_freeze,   mf);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
        id_src1_en = 1'b0; id_two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_wb_en = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic load_use();
        exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
        id_src1_en = 1'b1; id_src1 = 4'd3;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    initial begin
        bit h;
        clr();
        rst = 1'b1;
        load_use();
        branch_taken = 1'b1;
        mem_req = 1'b1;
        #1;
        check("rst.hazard", hazard, 0);
        ctl("rst", 0, 0, 0, 0, 0);
        check("rst.mem_err", mem_err, 0);
        check("rst.stall_cnt", stall_cnt, 0);
        check("rst.t4_mem_freeze", t4_mem_freeze, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clr();
        #1;
        ctl("idle", 0, 0, 0, 0, 0);
        check("idle.hazard", hazard, 0);
        check("idle.stall_cnt", stall_cnt, 0);

        // EXE RAW on src1 (non-load)
        exe_wb_en = 1'b1; exe_dest = 4'd3; id_src1_en = 1'b1; id_src1 = 4'd3;
        #1;
        h = !FWD;
        check("exe_raw.hazard", hazard, h);
        ctl("exe_raw", h, h, h, 0, 0);
        tick();
        if (h) exp_cnt++;
        check("exe_raw.stall_cnt", stall_cnt, exp_cnt);
        // load-use stalls in both configurations; run into saturation of the 2-bit counter
        exe_mem_r_en = 1'b1;
        #1;
        check("load_use.hazard", hazard, 1);
        ctl("load_use", 1, 1, 1, 0, 0);
        repeat (5) tick();
        exp_cnt += 5;
        check("load_use.stall_cnt", stall_cnt, exp_cnt);
        check("sat.t4_stall_cnt", t4_stall_cnt, sat3(exp_cnt));
        exe_dest = 4'd4;
        #1;
        check("dest_miss.hazard", hazard, 0);
        exe_dest = 4'd15; id_src1 = 4'd15;
        #1;
        check("r15.hazard", hazard, 1);
        id_src1_en = 1'b0;
        #1;
        check("src1_dis.hazard", hazard, 0);
        id_src2 = 4'd15; id_two_src = 1'b1;
        #1;
        check("exe_src2.hazard", hazard, 1);
        id_two_src = 1'b0;
        #1;
        check("exe_src2_dis.hazard", hazard, 0);
        clr();
        tick();

        // MEM-stage RAW
        mem_wb_en = 1'b1; mem_dest = 4'd7; id_src2 = 4'd7; id_two_src = 1'b0;
        #1;
        check("mem_src2_dis.hazard", hazard, 0);
        id_two_src = 1'b1;
        #1;
        check("mem_src2.hazard", hazard, !FWD);
        id_two_src = 1'b0; id_src1_en = 1'b1; id_src1 = 4'd7;
        #1;
        check("mem_src1.hazard", hazard, !FWD);
        id_src1 = 4'd6;
        #1;
        check("mem_src1_miss.hazard", hazard, 0);
        clr();
        tick();

        // priority: branch over stall, mem_freeze over both
        load_use();
        branch_taken = 1'b1;
        #1;
        check("br_haz.hazard", hazard, 1);
        ctl("br_haz", 0, 0, 0, 1, 0);
        tick();
        check("br_haz.stall_cnt", stall_cnt, exp_cnt);
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        check("mf_br.hazard", hazard, 1);
        ctl("mf_br", 0, 0, 0, 0, 1);
        branch_taken = 1'b0;
        #1;
        ctl("mf_haz", 0, 0, 0, 0, 1);
        mem_ready = 1'b1;
        #1;
        ctl("rdy_haz", 1, 1, 1, 0, 0);
        clr();
        tick();

        // three wait cycles, ready on the fourth
        mem_req = 1'b1;
        #1;
        ctl("wait1", 0, 0, 0, 0, 1);
        tick();
        mem_req = 1'b0;
        #1;
        check("wait2.mem_freeze", mem_freeze, 1);
        branch_taken = 1'b1;
        #1;
        ctl("wait2_br", 0, 0, 0, 0, 1);
        tick();
        check("wait3.mem_freeze", mem_freeze, 1);
        tick();
        mem_ready = 1'b1;
        #1;
        ctl("wait_rdy", 0, 0, 0, 1, 0);
        tick();
        clr();
        #1;
        check("back_run.mem_freeze", mem_freeze, 0);
        check("back_run.t4_mem_freeze", t4_mem_freeze, 0);
        check("back_run.mem_err", mem_err, 0);

        // timeout on the short-timeout instance
        mem_req = 1'b1;
        #1;
        check("to_req.t4_mem_freeze", t4_mem_freeze, 1);
        tick();
        mem_req = 1'b0;
        repeat (3) tick();
        check("to_last.t4_mem_err", t4_mem_err, 0);
        check("to_last.t4_mem_freeze", t4_mem_freeze, 1);
        tick();
        check("to_err.t4_mem_err", t4_mem_err, 1);
        check("to_err.mem_err", mem_err, 0);
        mem_ready = 1'b1; branch_taken = 1'b1;
        load_use();
        #1;
        check("err.t4_mem_freeze", t4_mem_freeze, 1);
        check("err.t4_flush", t4_flush, 0);
        check("err.t4_freeze_pc", t4_freeze_pc, 0);
        check("err.t4_freeze_ifid", t4_freeze_ifid, 0);
        check("err.t4_bubble_idexe", t4_bubble_idexe, 0);
        check("err_rdy.flush", flush, 1);
        tick();
        check("err_hold.t4_mem_err", t4_mem_err, 1);
        check("err_hold.t4_stall_cnt", t4_stall_cnt, sat3(exp_cnt));
        check("err_hold.stall_cnt", stall_cnt, exp_cnt);
        clr();
        #1;
        check("err_idle.t4_mem_freeze", t4_mem_freeze, 1);
        check("err_idle.mem_freeze", mem_freeze, 0);
        tick();

        // async reset in the middle of MEM_WAIT with wait_cnt=5
        mem_req = 1'b1;
        tick();
        mem_req = 1'b0;
        repeat (5) tick();
        check("w5.mem_freeze", mem_freeze, 1);
        #2;
        rst = 1'b1;
        load_use();
        branch_taken = 1'b1;
        #1;
        ctl("async_rst", 0, 0, 0, 0, 0);
        check("async_rst.hazard", hazard, 0);
        check("async_rst.mem_err", mem_err, 0);
        check("async_rst.stall_cnt", stall_cnt, 0);
        check("async_rst.t4_mem_err", t4_mem_err, 0);
        check("async_rst.t4_mem_freeze", t4_mem_freeze, 0);
        check("async_rst.t4_stall_cnt", t4_stall_cnt, 0);
        rst = 1'b0;
        clr();
        #1;
        check("post_rst.mem_freeze", mem_freeze, 0);
        check("post_rst.t4_mem_freeze", t4_mem_freeze, 0);
        tick();
        check("post_rst_clk.mem_freeze", mem_freeze, 0);
        check("post_rst_clk.mem_err", mem_err, 0);
        check("post_rst_clk.t4_mem_err", t4_mem_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
